// File: rtl/mem_bus_arbiter_if.sv
// Requester-side bundle of the shared byte bus.
// Master i occupies bit i, addr[32i+31:32i] and wdata[8i+7:8i].
interface mem_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]   m_req;
  logic [NUM_MASTERS-1:0]   m_lock;
  logic [NUM_MASTERS-1:0]   m_we;
  logic [32*NUM_MASTERS-1:0] m_addr;
  logic [8*NUM_MASTERS-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]   m_gnt;
  logic [NUM_MASTERS-1:0]   m_rvalid;
  logic [7:0]               m_rdata;

  modport master (
    output m_req, m_lock, m_we, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_lock, m_we, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// N-master byte bus arbiter onto one sync RAM and one IO port.
// Fixed or round-robin priority, bus lock, IO write back-pressure.
module mem_bus_arbiter #(
  parameter int         NUM_MASTERS    = 2,
  parameter int         RAM_ADDR_WIDTH = 17,
  parameter int         PRIO_MODE      = 0,
  parameter logic [2:0] IO_FULL_SEL    = 3'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_bus_arbiter_if.slave          bus,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata,
  output logic                      io_en,
  output logic [2:0]                io_sel,
  output logic                      io_wr,
  output logic [7:0]                io_wdata,
  input  logic [7:0]                io_rdata,
  input  logic                      io_full
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  typedef logic [IW-1:0] idx_t;

  logic [NUM_MASTERS-1:0] io_reg;
  logic [NUM_MASTERS-1:0] elig;
  logic                   have_win;
  idx_t                   win;
  logic                   gnt_ok;
  logic                   sel_we;
  logic [31:0]            sel_addr;
  logic [7:0]             sel_wdata;
  logic                   sel_io;
  idx_t                   nxt_ptr;

  idx_t                   rr_ptr;
  logic                   lock_vld;
  idx_t                   lock_id;
  logic                   rd_pend;
  logic                   rd_io;
  idx_t                   rd_owner;

  logic                   unused_addr;
  assign unused_addr = ^bus.m_addr;

  always_comb begin
    io_reg = '0;
    elig   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      io_reg[i] =
        bus.m_addr[32*i+RAM_ADDR_WIDTH -: 2] == 2'b11;
      elig[i] = bus.m_req[i] &
        ~(bus.m_we[i] & io_reg[i] & io_full &
          (bus.m_addr[32*i +: 3] == IO_FULL_SEL));
    end
  end

  // Reverse scans so the lowest index (or the one
  // nearest rr_ptr) is the last, winning, write.
  always_comb begin
    have_win = 1'b0;
    win      = '0;
    if (lock_vld) begin
      have_win = elig[lock_id];
      win      = lock_id;
    end else if (PRIO_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (elig[i]) begin
          have_win = 1'b1;
          win      = idx_t'(i);
        end
      end
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        int j;
        j = int'(rr_ptr) + k;
        if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
        if (elig[j]) begin
          have_win = 1'b1;
          win      = idx_t'(j);
        end
      end
    end
  end

  always_comb begin
    sel_we    = bus.m_we[0];
    sel_addr  = bus.m_addr[31:0];
    sel_wdata = bus.m_wdata[7:0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (win == idx_t'(i)) begin
        sel_we    = bus.m_we[i];
        sel_addr  = bus.m_addr[32*i +: 32];
        sel_wdata = bus.m_wdata[8*i +: 8];
      end
    end
  end

  assign gnt_ok    = have_win & ~rst;
  assign sel_io    = sel_addr[RAM_ADDR_WIDTH -: 2] == 2'b11;
  assign ram_addr  = sel_addr[RAM_ADDR_WIDTH-1:0];
  assign ram_wdata = sel_wdata;
  assign io_wdata  = sel_wdata;
  assign io_sel    = sel_addr[2:0];
  assign ram_we    = gnt_ok & sel_we & ~sel_io;
  assign io_en     = gnt_ok & sel_io;
  assign io_wr     = gnt_ok & sel_we;

  assign bus.m_gnt = gnt_ok ? (NUM_MASTERS'(1) << win) : '0;

  assign nxt_ptr = (win == idx_t'(NUM_MASTERS - 1)) ?
                   '0 : idx_t'(win + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
      rd_pend  <= 1'b0;
      rd_io    <= 1'b0;
      rd_owner <= '0;
    end else begin
      rd_pend <= have_win & ~sel_we;
      if (have_win & ~sel_we) begin
        rd_owner <= win;
        rd_io    <= sel_io;
      end
      if (have_win) rr_ptr <= nxt_ptr;
      if (have_win & bus.m_lock[win]) begin
        lock_vld <= 1'b1;
        lock_id  <= win;
      end else if (have_win & lock_vld) begin
        lock_vld <= 1'b0;
      end else if (lock_vld & ~bus.m_req[lock_id] &
                   ~bus.m_lock[lock_id]) begin
        lock_vld <= 1'b0;
      end
    end
  end

  // A read in flight when rst rises is dropped, not returned.
  assign bus.m_rvalid = (rd_pend & ~rst) ?
                        (NUM_MASTERS'(1) << rd_owner) : '0;
  assign bus.m_rdata  = rd_io ? io_rdata : ram_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench: 2-master fixed and 3-master round-robin arbiters on shared
// stimulus, each checked every cycle against a behavioural model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, lck, we;
  logic [31:0] ad [3];
  logic [7:0]  wd [3];
  logic        io_full;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter_if #(.NUM_MASTERS(2)) bus_a ();
  mem_bus_arbiter_if #(.NUM_MASTERS(3)) bus_b ();

  assign bus_a.m_req   = req[1:0];
  assign bus_a.m_lock  = lck[1:0];
  assign bus_a.m_we    = we[1:0];
  assign bus_a.m_addr  = {ad[1], ad[0]};
  assign bus_a.m_wdata = {wd[1], wd[0]};
  assign bus_b.m_req   = req;
  assign bus_b.m_lock  = lck;
  assign bus_b.m_we    = we;
  assign bus_b.m_addr  = {ad[2], ad[1], ad[0]};
  assign bus_b.m_wdata = {wd[2], wd[1], wd[0]};

  logic        ram_we_a, io_en_a, io_wr_a;
  logic [16:0] ram_addr_a;
  logic [7:0]  ram_wdata_a, ram_rdata_a, io_wdata_a, io_rdata_a;
  logic [2:0]  io_sel_a;
  logic        ram_we_b, io_en_b, io_wr_b;
  logic [16:0] ram_addr_b;
  logic [7:0]  ram_wdata_b, ram_rdata_b, io_wdata_b, io_rdata_b;
  logic [2:0]  io_sel_b;

  mem_bus_arbiter #(
    .NUM_MASTERS(2), .RAM_ADDR_WIDTH(17),
    .PRIO_MODE(0), .IO_FULL_SEL(3'd0)
  ) u_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a),
    .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a),
    .io_en(io_en_a), .io_sel(io_sel_a), .io_wr(io_wr_a),
    .io_wdata(io_wdata_a), .io_rdata(io_rdata_a),
    .io_full(io_full)
  );

  mem_bus_arbiter #(
    .NUM_MASTERS(3), .RAM_ADDR_WIDTH(17),
    .PRIO_MODE(1), .IO_FULL_SEL(3'd0)
  ) u_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
    .io_en(io_en_b), .io_sel(io_sel_b), .io_wr(io_wr_b),
    .io_wdata(io_wdata_b), .io_rdata(io_rdata_b),
    .io_full(io_full)
  );

  function automatic logic [7:0] init_byte(int i);
    if (i == 0)   return 8'h11;
    if (i == 256) return 8'hA5;
    return 8'(i * 37 + 5);
  endfunction

  logic [7:0] ram_a [1024];
  logic [7:0] ram_b [1024];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram_a[i] <= init_byte(i);
    end else if (ram_we_a) begin
      ram_a[ram_addr_a[9:0]] <= ram_wdata_a;
    end
    ram_rdata_a <= ram_a[ram_addr_a[9:0]];
    if (io_en_a && !io_wr_a) io_rdata_a <= 8'h38 ^ {5'b0, io_sel_a};
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram_b[i] <= init_byte(i);
    end else if (ram_we_b) begin
      ram_b[ram_addr_b[9:0]] <= ram_wdata_b;
    end
    ram_rdata_b <= ram_b[ram_addr_b[9:0]];
    if (io_en_b && !io_wr_b) io_rdata_b <= 8'h38 ^ {5'b0, io_sel_b};
  end

  // Reference model: instance 0 = 2 masters fixed, 1 = 3 masters rr.
  int         own [2];
  int         rr  [2];
  int         win [2];
  int         pown[2];
  bit         pend[2];
  logic [7:0] pdat[2];
  logic [7:0] mm  [2][1024];

  function automatic int nm(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic bit is_io(logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pick(int k);
    int n;
    bit el [3];
    n = nm(k);
    for (int i = 0; i < 3; i++) el[i] = 1'b0;
    for (int i = 0; i < n; i++)
      el[i] = req[i] && !(we[i] && is_io(ad[i]) &&
                          ad[i][2:0] == 3'd0 && io_full);
    win[k] = -1;
    if (rst) return;
    if (own[k] >= 0) begin
      if (el[own[k]]) win[k] = own[k];
    end else if (k == 0) begin
      for (int i = 0; i < n; i++)
        if (el[i]) begin win[k] = i; break; end
    end else begin
      for (int j = 0; j < n; j++) begin
        int m;
        m = (rr[k] + j) % n;
        if (el[m]) begin win[k] = m; break; end
      end
    end
  endtask

  task automatic check(int k);
    logic [2:0]  g, rv;
    logic        rwe, ioe, iow;
    logic [16:0] ra;
    logic [2:0]  sel;
    logic [7:0]  rd, rwd;
    int          w;
    if (k == 0) begin
      g = {1'b0, bus_a.m_gnt}; rv = {1'b0, bus_a.m_rvalid};
      rd = bus_a.m_rdata; rwe = ram_we_a; ioe = io_en_a;
      iow = io_wr_a; ra = ram_addr_a; sel = io_sel_a;
      rwd = ram_wdata_a;
    end else begin
      g = bus_b.m_gnt; rv = bus_b.m_rvalid; rd = bus_b.m_rdata;
      rwe = ram_we_b; ioe = io_en_b; iow = io_wr_b;
      ra = ram_addr_b; sel = io_sel_b; rwd = ram_wdata_b;
    end
    pick(k);
    w = win[k];
    chk($sformatf("gnt%0d", k), g, (w >= 0) ? 3'(1 << w) : 3'd0);
    chk($sformatf("ram_we%0d", k), rwe,
        w >= 0 && we[w] && !is_io(ad[w]));
    chk($sformatf("io_en%0d", k), ioe, w >= 0 && is_io(ad[w]));
    chk($sformatf("io_wr%0d", k), iow, w >= 0 && we[w]);
    chk($sformatf("rvalid%0d", k), rv,
        (!rst && pend[k]) ? 3'(1 << pown[k]) : 3'd0);
    if (!rst && pend[k]) chk($sformatf("rdata%0d", k), rd, pdat[k]);
    if (w >= 0) begin
      chk($sformatf("ram_addr%0d", k), ra, ad[w][16:0]);
      chk($sformatf("io_sel%0d", k), sel, ad[w][2:0]);
      if (we[w]) chk($sformatf("wdata%0d", k), rwd, wd[w]);
    end
  endtask

  task automatic update(int k);
    int w;
    w = win[k];
    if (rst) begin
      own[k] = -1; rr[k] = 0; pend[k] = 1'b0;
      for (int i = 0; i < 1024; i++) mm[k][i] = init_byte(i);
      return;
    end
    pend[k] = 1'b0;
    if (w >= 0) begin
      rr[k] = (w + 1) % nm(k);
      if (we[w]) begin
        if (!is_io(ad[w])) mm[k][ad[w][9:0]] = wd[w];
      end else begin
        pend[k] = 1'b1;
        pown[k] = w;
        pdat[k] = is_io(ad[w]) ? (8'h38 ^ {5'b0, ad[w][2:0]})
                               : mm[k][ad[w][9:0]];
      end
      if (lck[w]) own[k] = w;
      else if (w == own[k]) own[k] = -1;
    end else if (own[k] >= 0 && !req[own[k]] && !lck[own[k]]) begin
      own[k] = -1;
    end
  endtask

  task automatic settle();
    #1;
    check(0);
    check(1);
  endtask

  task automatic adv();
    @(posedge clk);
    update(0);
    update(1);
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic set_m(int i, bit r, bit l, bit w,
                       logic [31:0] a, logic [7:0] d);
    req[i] = r; lck[i] = l; we[i] = w; ad[i] = a; wd[i] = d;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; rr[k] = 0; pend[k] = 1'b0; pown[k] = 0;
      pdat[k] = '0; win[k] = -1;
    end
    rst = 1'b1;
    io_full = 1'b0;
    set_m(0, 1, 0, 1, 32'h0000_0005, 8'h44);
    set_m(1, 1, 0, 0, 32'h0003_0001, 8'h00);
    set_m(2, 1, 0, 1, 32'h0003_0002, 8'h55);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("rst_gnt", bus_a.m_gnt, 2'b00);
      chk("rst_ram_we", ram_we_a, 1'b0);
      chk("rst_io_en", io_en_b, 1'b0);
      chk("rst_rvalid", bus_a.m_rvalid, 2'b00);
      adv();
    end
    rst = 1'b0;

    set_m(0, 1, 0, 0, 32'h0000_0000, 8'h00);
    set_m(1, 1, 0, 0, 32'h0000_0100, 8'h00);
    set_m(2, 0, 0, 0, 32'h0000_0000, 8'h00);
    for (int c = 0; c < 2; c++) begin
      settle(); chk("fix_gnt_m0", bus_a.m_gnt, 2'b01); adv();
    end
    req = 3'b010;
    settle(); chk("fix_gnt_m1", bus_a.m_gnt, 2'b10); adv();
    req = 3'b000;
    settle();
    chk("fix_rvalid", bus_a.m_rvalid, 2'b10);
    chk("fix_rdata", bus_a.m_rdata, 8'hA5);
    adv();

    do_reset(1);
    set_m(0, 1, 0, 0, 32'h0000_0010, 8'h00);
    set_m(1, 1, 0, 0, 32'h0000_0020, 8'h00);
    set_m(2, 1, 0, 0, 32'h0000_0030, 8'h00);
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("rr_gnt", bus_b.m_gnt, 3'b001 << (c % 3));
      adv();
    end

    do_reset(1);
    set_m(0, 1, 0, 1, 32'h0003_0000, 8'h5A);
    set_m(1, 1, 0, 0, 32'h0000_0100, 8'h00);
    set_m(2, 0, 0, 0, 32'h0000_0000, 8'h00);
    io_full = 1'b1;
    settle();
    chk("full_gnt", bus_a.m_gnt, 2'b10);
    chk("full_io_en", io_en_a, 1'b0);
    adv();
    io_full = 1'b0;
    settle();
    chk("unfull_gnt", bus_a.m_gnt, 2'b01);
    chk("unfull_io_en", io_en_a, 1'b1);
    chk("unfull_io_sel", io_sel_a, 3'd0);
    chk("unfull_io_wr", io_wr_a, 1'b1);
    chk("unfull_rdata", bus_a.m_rdata, 8'hA5);
    adv();
    req = 3'b000;
    cyc();

    do_reset(1);
    set_m(0, 0, 0, 0, 32'h0000_0000, 8'h00);
    set_m(1, 1, 1, 1, 32'h0000_0200, 8'h71);
    settle(); chk("lock_gnt0", bus_a.m_gnt, 2'b10); adv();
    for (int i = 1; i < 4; i++) begin
      req[0] = 1'b1;
      set_m(1, 1, (i < 3), 1, 32'h0000_0200 + i, 8'(8'h71 + i));
      settle(); chk("lock_gnt", bus_a.m_gnt, 2'b10); adv();
    end
    lck = 3'b000;
    settle(); chk("lock_release", bus_a.m_gnt, 2'b01); adv();
    req = 3'b000;
    cyc();

    do_reset(1);
    set_m(0, 1, 0, 0, 32'h0003_0004, 8'h00);
    set_m(1, 0, 0, 0, 32'h0000_0000, 8'h00);
    cyc();
    ad[0] = 32'h0000_0000;
    settle();
    chk("src_io_rv", bus_a.m_rvalid, 2'b01);
    chk("src_io_data", bus_a.m_rdata, 8'h3C);
    adv();
    req = 3'b000;
    settle();
    chk("src_ram_rv", bus_a.m_rvalid, 2'b01);
    chk("src_ram_data", bus_a.m_rdata, 8'h11);
    adv();

    set_m(0, 1, 0, 0, 32'h0000_0100, 8'h00);
    cyc();
    rst = 1'b1;
    req = 3'b000;
    settle(); chk("rst_drop_rv", bus_a.m_rvalid, 2'b00); adv();
    rst = 1'b0;
    settle(); chk("post_rst_rv", bus_a.m_rvalid, 2'b00); adv();

    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        req[i] = ($urandom_range(0, 9) < 7);
        lck[i] = ($urandom_range(0, 4) == 0);
        we[i]  = $urandom_range(0, 1) == 1;
        ad[i]  = ($urandom_range(0, 3) == 0) ?
                 (32'h0003_0000 | ($urandom & 32'hFFFC_0007)) :
                 ($urandom & 32'hFFFC_03FF);
        wd[i]  = 8'($urandom);
      end
      io_full = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
